// File: rtl/hash_auth_pkg.sv
// hash_auth_pkg: shared types and constants for the hash authorisation
// controller.
//   state_t : controller FSM states (IDLE, RECV, DECIDE, LOCKED)
//   BYTE_W  : width of one hash byte
package hash_auth_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        DECIDE = 2'd2,
        LOCKED = 2'd3
    } state_t;

endpackage

// File: rtl/hash_auth_ctrl_lockout_timer.sv
// lockout_timer: one-shot down-counter that times the lockout period.
// A start pulse loads LOCK_CYCLES-1. The counter then runs down to 0, one step per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load the counter and go busy
//   busy       : counter is running (LOCK_CYCLES cycles after start)
//   last       : final busy cycle (counter at 0)
module lockout_timer #(
    parameter int LOCK_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic last
);

    localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            cnt  <= CW'(LOCK_CYCLES - 1);
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign last = busy & (cnt == '0);

endmodule

// File: rtl/hash_auth_ctrl.sv
// hash_auth_ctrl: byte-serial hash authorisation controller.
// It compares a candidate hash, received one byte per handshake, against an
// enrolled template. It then issues a one-cycle grant/deny verdict.
// Optional lockout after MAX_TRIES consecutive failures is enabled by
// defining HASH_AUTH_LOCKOUT_EN.
//
// Handshake: a byte is transferred on a rising edge where in_valid and in_ready
// are both 1. in_ready is a registered Moore output and does not depend on in_valid.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   tpl_load/tpl_data : enrol template (byte 0 in the MSBs)
//   in_valid/in_byte/in_last/in_ready : candidate byte stream
//   result_valid      : one-cycle verdict strobe
//   granted           : verdict is match (0 unless result_valid)
//   locked            : lockout active
//   fail_cnt          : consecutive failures so far
//   dbg_state         : current FSM state (for observation)
module hash_auth_ctrl
    import hash_auth_pkg::*;
#(
    parameter int HASH_BYTES  = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              tpl_load,
    input  logic [HASH_BYTES*BYTE_W-1:0]      tpl_data,
    input  logic                              in_valid,
    input  logic [BYTE_W-1:0]                 in_byte,
    input  logic                              in_last,
    output logic                              in_ready,
    output logic                              result_valid,
    output logic                              granted,
    output logic                              locked,
    output logic [$clog2(MAX_TRIES+1)-1:0]    fail_cnt,
    output logic [1:0]                        dbg_state
);

    localparam int IW = $clog2(HASH_BYTES + 1);
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam logic [IW-1:0] IDX_FULL = IW'(HASH_BYTES);
    localparam logic [FW-1:0] TRIES    = FW'(MAX_TRIES);
    localparam logic [FW-1:0] TRIES_M1 = FW'(MAX_TRIES - 1);

    state_t                         state;
    logic [HASH_BYTES*BYTE_W-1:0]   tpl;
    logic                           tpl_vld;
    logic [IW-1:0]                  idx;
    logic                           miss;
    logic                           len_err;

    logic [BYTE_W-1:0] tpl_byte;
    logic              accept;
    logic              load_ok;
    logic              in_range;
    logic              miss_nxt;
    logic              len_err_nxt;
    logic [IW-1:0]     idx_nxt;
    logic              verdict;

    // Template byte addressed by the current index. idx is 0 in IDLE, so the
    // first byte of an attempt always sees the template as it was before any
    // same-cycle tpl_load.
    always_comb begin
        tpl_byte = '0;
        for (int i = 0; i < HASH_BYTES; i++) begin
            if (idx == IW'(i)) begin
                tpl_byte = tpl[(HASH_BYTES-1-i)*BYTE_W +: BYTE_W];
            end
        end
    end

    assign accept   = in_valid & in_ready;
    assign load_ok  = tpl_load & ((state == IDLE) | (state == LOCKED));
    assign in_range = (idx != IDX_FULL);

    // Comparison state as it will be after this byte. The verdict is computed
    // from these values, so it can be registered on the cycle the last byte
    // is accepted.
    assign miss_nxt    = miss | (in_range & (in_byte != tpl_byte));
    assign len_err_nxt = len_err | ~in_range;
    assign idx_nxt     = in_range ? idx + IW'(1) : idx;
    assign verdict     = (tpl_vld | load_ok) & ~miss_nxt & ~len_err_nxt &
                         (idx_nxt == IDX_FULL);

    assign dbg_state = state;

`ifdef HASH_AUTH_LOCKOUT_EN
    logic lock_start;
    logic lock_busy;
    logic lock_last;

    assign lock_start = (state == DECIDE) & ~granted & (fail_cnt == TRIES_M1);

    lockout_timer #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lockout_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (lock_start),
        .busy  (lock_busy),
        .last  (lock_last)
    );
`else
    assign locked = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tpl          <= '0;
            tpl_vld      <= 1'b0;
            idx          <= '0;
            miss         <= 1'b0;
            len_err      <= 1'b0;
            in_ready     <= 1'b1;
            result_valid <= 1'b0;
            granted      <= 1'b0;
            fail_cnt     <= '0;
`ifdef HASH_AUTH_LOCKOUT_EN
            locked       <= 1'b0;
`endif
        end else begin
            if (load_ok) begin
                tpl     <= tpl_data;
                tpl_vld <= 1'b1;
            end

            case (state)
                IDLE, RECV: begin
                    if (accept) begin
                        idx     <= idx_nxt;
                        miss    <= miss_nxt;
                        len_err <= len_err_nxt;
                        if (in_last) begin
                            state        <= DECIDE;
                            in_ready     <= 1'b0;
                            result_valid <= 1'b1;
                            granted      <= verdict;
                        end else begin
                            state <= RECV;
                        end
                    end
                end

                DECIDE: begin
                    result_valid <= 1'b0;
                    granted      <= 1'b0;
                    // Clear here: both IDLE and LOCKED follow, and LOCKED only exits to IDLE.
                    idx          <= '0;
                    miss         <= 1'b0;
                    len_err      <= 1'b0;
                    if (granted) begin
                        fail_cnt <= '0;
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end else begin
`ifdef HASH_AUTH_LOCKOUT_EN
                        if (fail_cnt == TRIES_M1) begin
                            fail_cnt <= TRIES;
                            state    <= LOCKED;
                            locked   <= 1'b1;
                        end else begin
                            fail_cnt <= fail_cnt + FW'(1);
                            state    <= IDLE;
                            in_ready <= 1'b1;
                        end
`else
                        if (fail_cnt != TRIES) begin
                            fail_cnt <= fail_cnt + FW'(1);
                        end
                        state    <= IDLE;
                        in_ready <= 1'b1;
`endif
                    end
                end

                LOCKED: begin
`ifdef HASH_AUTH_LOCKOUT_EN
                    if (lock_last) begin
                        state    <= IDLE;
                        locked   <= 1'b0;
                        fail_cnt <= '0;
                        in_ready <= 1'b1;
                    end
`else
                    state    <= IDLE;
                    in_ready <= 1'b1;
`endif
                end

                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
